// File: rtl/sr_bank_arbiter.sv
// sr_bank_arbiter: round-robin arbitration of two SR command requesters onto a shared bank of SR flag cells.
module sr_bank_arbiter #(
  parameter  int ADDR_W = 3,
  localparam int WIDTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_idx,
  input  logic              req0_s,
  input  logic              req0_r,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_idx,
  input  logic              req1_s,
  input  logic              req1_r,
  input  logic              err_clr,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  q_bar,
  output logic              busy,
  output logic              err,
  output logic              err_src
);
  logic              last_grant_q, last_grant_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              s_q, s_d, r_q, r_d, src_q, src_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              err_q, err_d, err_src_q, err_src_d;
  logic              acc0, acc1, forbid;
  always_comb begin
    req0_ready   = !rst && req0_valid && (!req1_valid || last_grant_q);
    req1_ready   = !rst && req1_valid && (!req0_valid || !last_grant_q);
    acc0         = req0_valid && req0_ready;
    acc1         = req1_valid && req1_ready;
    last_grant_d = acc0 ? 1'b0 : acc1 ? 1'b1 : last_grant_q;
    busy_d       = acc0 || acc1;
    idx_d        = acc0 ? req0_idx : acc1 ? req1_idx : idx_q;
    s_d          = acc0 ? req0_s : acc1 ? req1_s : s_q;
    r_d          = acc0 ? req0_r : acc1 ? req1_r : r_q;
    src_d        = acc1 ? 1'b1 : acc0 ? 1'b0 : src_q;
    // Forbidden S=R=1 leaves the cell untouched; only the error flags react.
    forbid       = busy_q && s_q && r_q;
    q_d          = q_q;
    if (busy_q && (s_q != r_q))
      q_d[idx_q] = s_q;
    err_d        = forbid ? 1'b1 : err_clr ? 1'b0 : err_q;
    err_src_d    = forbid ? src_q : err_src_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
      idx_q        <= '0;
      s_q          <= 1'b0;
      r_q          <= 1'b0;
      src_q        <= 1'b0;
      q_q          <= '0;
      err_q        <= 1'b0;
      err_src_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      idx_q        <= idx_d;
      s_q          <= s_d;
      r_q          <= r_d;
      src_q        <= src_d;
      q_q          <= q_d;
      err_q        <= err_d;
      err_src_q    <= err_src_d;
    end
  end
  assign q       = q_q;
  assign q_bar   = ~q_q;
  assign busy    = busy_q;
  assign err     = err_q;
  assign err_src = err_src_q;
endmodule

// File: tb/tb_sr_bank_arbiter.sv
// tb_sr_bank_arbiter: directed vectors with hand-computed expectations for sr_bank_arbiter.
module tb_sr_bank_arbiter;
  logic       clk = 0, rst = 0;
  logic       req0_valid = 0, req0_ready, req0_s = 0, req0_r = 0;
  logic       req1_valid = 0, req1_ready, req1_s = 0, req1_r = 0;
  logic [2:0] req0_idx = 0, req1_idx = 0;
  logic       err_clr = 0;
  logic [7:0] q, q_bar;
  logic       busy, err, err_src;
  int         n_vec = 0, n_bad = 0;
  sr_bank_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_idx(req0_idx), .req0_s(req0_s), .req0_r(req0_r),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_idx(req1_idx), .req1_s(req1_s), .req1_r(req1_r),
    .err_clr(err_clr), .q(q), .q_bar(q_bar), .busy(busy), .err(err), .err_src(err_src)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic cmd0(input logic v, input logic [2:0] i, input logic s, input logic r);
    req0_valid = v; req0_idx = i; req0_s = s; req0_r = r;
  endtask
  task automatic cmd1(input logic v, input logic [2:0] i, input logic s, input logic r);
    req1_valid = v; req1_idx = i; req1_s = s; req1_r = r;
  endtask
  int acc0_n, acc1_n;
  initial begin
    rst = 1;
    cmd0(1, 0, 0, 0);
    repeat (5) step();
    chk("rst_q", q, 8'h00);
    chk("rst_qbar", q_bar, 8'hFF);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_errsrc", err_src, 0);
    chk("rst_ready0", req0_ready, 0);
    cmd0(0, 0, 0, 0);
    rst = 0;
    step();
    cmd0(1, 3, 1, 0);
    #1 chk("set_ready0", req0_ready, 1);
    step();
    chk("set_busy", busy, 1);
    chk("set_q_early", q, 8'h00);
    cmd0(0, 0, 0, 0);
    step();
    chk("set_q", q, 8'h08);
    chk("set_qbar", q_bar, 8'hF7);
    chk("set_busy_off", busy, 0);
    cmd0(1, 3, 0, 0);
    step();
    cmd0(0, 0, 0, 0);
    step();
    chk("hold_q", q, 8'h08);
    cmd0(1, 3, 0, 1);
    step();
    cmd0(0, 0, 0, 0);
    step();
    chk("reset_q", q, 8'h00);
    // a lone req1 hold command makes last_grant=1 so req0 leads the contention run
    cmd1(1, 7, 0, 0);
    step();
    cmd1(0, 0, 0, 0);
    step();
    chk("lg_q", q, 8'h00);
    cmd0(1, 0, 1, 0);
    cmd1(1, 7, 1, 0);
    acc0_n = 0; acc1_n = 0;
    #1 chk("cont_rdy0_a", req0_ready, 1);
    chk("cont_rdy1_a", req1_ready, 0);
    acc0_n += int'(req0_ready); acc1_n += int'(req1_ready);
    step();
    chk("cont_rdy0_b", req0_ready, 0);
    chk("cont_rdy1_b", req1_ready, 1);
    chk("cont_q_b", q, 8'h00);
    acc0_n += int'(req0_ready); acc1_n += int'(req1_ready);
    step();
    chk("cont_q_c", q, 8'h01);
    chk("cont_rdy0_c", req0_ready, 1);
    acc0_n += int'(req0_ready); acc1_n += int'(req1_ready);
    step();
    chk("cont_q_d", q, 8'h81);
    chk("cont_rdy1_d", req1_ready, 1);
    acc0_n += int'(req0_ready); acc1_n += int'(req1_ready);
    step();
    cmd0(0, 0, 0, 0);
    cmd1(0, 0, 0, 0);
    chk("cont_acc0", acc0_n, 2);
    chk("cont_acc1", acc1_n, 2);
    step();
    chk("cont_q_end", q, 8'h81);
    cmd0(1, 5, 1, 0);
    step();
    cmd0(0, 0, 0, 0);
    step();
    chk("f_preset", q, 8'hA1);
    cmd1(1, 5, 1, 1);
    step();
    cmd1(0, 0, 0, 0);
    step();
    chk("f_q", q, 8'hA1);
    chk("f_err", err, 1);
    chk("f_src", err_src, 1);
    err_clr = 1;
    step();
    err_clr = 0;
    chk("f_clr", err, 0);
    chk("f_src_hold", err_src, 1);
    cmd0(1, 5, 1, 1);
    step();
    cmd0(0, 0, 0, 0);
    err_clr = 1;
    step();
    err_clr = 0;
    chk("f_setwins_err", err, 1);
    chk("f_setwins_src", err_src, 0);
    chk("f_setwins_q", q, 8'hA1);
    step();
    chk("f_sticky", err, 1);
    cmd0(1, 2, 1, 0);
    step();
    chk("b2b_busy1", busy, 1);
    cmd0(1, 2, 0, 1);
    step();
    cmd0(0, 0, 0, 0);
    chk("b2b_q_set", q, 8'hA5);
    chk("b2b_busy2", busy, 1);
    step();
    chk("b2b_q_clr", q, 8'hA1);
    chk("b2b_busy_off", busy, 0);
    cmd0(1, 4, 1, 0);
    step();
    chk("mid_busy", busy, 1);
    #2 rst = 1;
    #1 chk("mid_async_busy", busy, 0);
    chk("mid_async_q", q, 8'h00);
    cmd0(0, 0, 0, 0);
    step();
    step();
    chk("mid_q4", q[4], 0);
    rst = 0;
    step();
    chk("mid_q_after", q, 8'h00);
    cmd0(1, 1, 0, 0);
    cmd1(1, 1, 0, 0);
    #1 chk("mid_rr_rdy0", req0_ready, 1);
    chk("mid_rr_rdy1", req1_ready, 0);
    step();
    cmd0(0, 0, 0, 0);
    cmd1(0, 0, 0, 0);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/sr_bank_arbiter.md
# sr_bank_arbiter

Shares one bank of WIDTH set/reset flag cells between two command requesters. Each cell follows standard SR flip-flop rules: hold, reset, set, and the forbidden S=R=1 case. The block grants one requester per cycle on a round-robin basis and registers the accepted command. The command is applied to the addressed cell on the following clock edge. It sits between two control agents and the shared status-flag bank, and it is the only writer of the flags.

## Interface
Parameters:
- ADDR_W, 3, width of the cell index.
- WIDTH, 2**ADDR_W, number of SR cells (fixed, not overridable independently).

Ports:
- clk  in  1  rising-edge clock; one clock.
- rst  in  1  reset; asynchronous, active-high.
- req0_valid  in  1  requester 0 has a command.
- req0_ready  out  1  requester 0 command accepted this cycle (combinational).
- req0_idx  in  ADDR_W  target cell for requester 0.
- req0_s  in  1  set bit for requester 0.
- req0_r  in  1  reset bit for requester 0.
- req1_valid, req1_ready, req1_idx, req1_s, req1_r: same as requester 0, for requester 1.
- err_clr  in  1  clears the sticky error flag.
- q  out  WIDTH  cell states.
- q_bar  out  WIDTH  always ~q.
- busy  out  1  command stage holds an accepted, not-yet-applied command.
- err  out  1  sticky; a forbidden S=R=1 command was applied.
- err_src  out  1  requester that issued the most recent forbidden command.

## Operation
Arbitration (combinational, from the valids and last_grant):
- Only one valid: that requester's ready=1.
- Both valid: the requester that was not granted last gets ready=1. The other gets ready=0 and must hold its valid, idx, s and r stable until accepted.
- Neither valid: both readies=0.
- last_grant updates only on an accepted handshake (valid&&ready). Its reset value is 1, so requester 0 wins the first contention.

Command stage:
- An accepted command registers {idx, s, r, src} and sets busy=1.
- The stage never stalls. It always applies on the next edge, so acceptance is possible every cycle (back-to-back).

Apply, per SR rules, on cell q[idx]:
- s=0, r=0: hold.
- s=0, r=1: q[idx]=0.
- s=1, r=0: q[idx]=1.
- s=1, r=1: forbidden. q[idx] is unchanged, err=1, err_src=src.

Other rules:
- Cells not addressed always hold.
- err_clr=1 clears err on the next edge. If a forbidden command applies in the same cycle as err_clr, set wins: err stays 1 and err_src updates.
- err_src holds its value when err is cleared.

## Timing
- Reset values: q=0, q_bar=all ones, busy=0, err=0, err_src=0, last_grant=1, stage empty. All outputs take these values immediately when rst asserts (asynchronous).
- Accept at edge N: busy=1 after edge N. q, q_bar, err and err_src update at edge N+1. Latency from valid to flag change is 1 cycle after acceptance.
- busy=0 after edge N+1 unless another command is accepted at edge N+1.
- Back-to-back commands to the same idx apply in acceptance order. The second command observes the result of the first.
- rst asserted mid-operation drops any staged command, and that command is never applied. Handshakes present during reset are not accepted: readies are forced to 0 while rst=1.

## Test plan
- Reset: assert rst for 5 cycles with req0_valid=1 -> q=8'h00, q_bar=8'hFF, busy=0, err=0, req0_ready=0.
- Set/reset/hold on requester 0 only:
  - idx=3, s=1, r=0 -> q=8'h08 one cycle after accept.
  - Then idx=3, s=0, r=0 -> q stays 8'h08.
  - Then s=0, r=1 -> q=8'h00.
- Contention: both valid every cycle. Requester 0 sets idx 0, requester 1 sets idx 7. Grants alternate 0,1,0,1 with req0 first. q becomes 8'h01 then 8'h81, and each requester is accepted exactly once per 2 cycles.
- Forbidden command: q[5]=1, then requester 1 sends idx=5, s=1, r=1 -> q[5] stays 1, err=1, err_src=1.
  - err_clr pulse -> err=0.
  - err_clr applied in the same cycle as a new forbidden command from requester 0 -> err=1, err_src=0.
- Back-to-back same cell: accept set then reset on idx 2 in consecutive cycles -> q[2]=1 for exactly one cycle, then 0. busy is high for 2 cycles.
- Reset mid-operation: accept set idx 4, then assert rst before the next edge -> q[4] never becomes 1, busy=0. After rst deasserts, requester 0 wins the first contention.
